// File: rtl/rs_syndrome_ctrl.sv
// Reed-Solomon syndrome generator over GF(2^8) (poly 0x11D), Horner accumulation, IDLE/ACCUM/HOLD handshake FSM.
// Optional `RS_SYND_ERRFLAG_EN builds a registered nonzero-syndrome flag on syn_err.
module rs_syndrome_ctrl #(
  parameter int N     = 255,
  parameter int TWO_T = 16,
  parameter int FCR   = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  input  logic [7:0]           in_data,
  output logic                 in_ready,
  output logic                 syn_valid,
  input  logic                 syn_ready,
  output logic [8*TWO_T-1:0]   syn_data,
  output logic                 syn_err
);

  localparam int CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {IDLE, ACCUM, HOLD} state_t;

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = x[7] ? ((x << 1) ^ 8'h1D) : (x << 1);
    end
    return p;
  endfunction

  function automatic logic [7:0] gf_pow(input int e);
    logic [7:0] r;
    r = 8'h01;
    for (int i = 0; i < e; i++) r = gf_mul(r, 8'h02);
    return r;
  endfunction

  state_t                  state;
  logic [CW-1:0]           count;
  logic [TWO_T-1:0][7:0]   s, s_next;
  logic                    last;

  // One constant multiplier per syndrome; the root is folded at elaboration.
  for (genvar j = 0; j < TWO_T; j++) begin : g_lane
    localparam logic [7:0] ROOT = gf_pow((FCR + j) % 255);
    assign s_next[j] = gf_mul(s[j], ROOT) ^ in_data;
  end

  assign last     = (count == CW'(N - 1));
  assign in_ready = !rst && (state != HOLD);
  assign syn_data = s;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      count     <= '0;
      s         <= '0;
      syn_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          s     <= {TWO_T{in_data}};
          count <= CW'(1);
          state <= ACCUM;
        end
        ACCUM: if (in_valid) begin
          s <= s_next;
          // count parks at 0 in HOLD so it never wraps for small N
          if (last) begin
            count     <= '0;
            state     <= HOLD;
            syn_valid <= 1'b1;
          end else begin
            count <= count + CW'(1);
          end
        end
        HOLD: if (syn_ready) begin
          state     <= IDLE;
          syn_valid <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef RS_SYND_ERRFLAG_EN
  logic err_q;
  always_ff @(posedge clk) begin
    if (rst) err_q <= 1'b0;
    else if (state == ACCUM && in_valid && last) err_q <= |s_next;
  end
  assign syn_err = err_q;
`else
  assign syn_err = 1'b0;
`endif

endmodule
